// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding network:
// address width, special register tags, source codes, tag entry.
package fwd_pkg;

    localparam int AW = 6;

    localparam logic [AW-1:0] ZERO_ADDR = 6'd0;
    localparam logic [AW-1:0] HI_ADDR   = 6'd32;
    localparam logic [AW-1:0] LO_ADDR   = 6'd33;

    localparam logic [1:0] SRC_RF  = 2'b00;
    localparam logic [1:0] SRC_S0  = 2'b01;
    localparam logic [1:0] SRC_S1  = 2'b10;
    localparam logic [1:0] SRC_S2P = 2'b11;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] wa;
    } tag_t;

    function automatic logic [1:0] src_of(input int k);
        if (k == 0)
            return SRC_S0;
        else if (k == 1)
            return SRC_S1;
        else
            return SRC_S2P;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-channel operand resolver: picks the youngest in-flight
// producer of the requested register, else the register file.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3
) (
    input  tag_t [DEPTH-1:0]        tags,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    input  logic [DEPTH-1:0]        stage_dvalid,
    input  logic                    en,
    input  logic [AW-1:0]           addr,
    input  logic [DATA_W-1:0]       rf_data,
    output logic [DATA_W-1:0]       data,
    output logic                    hazard,
    output logic [1:0]              src
);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        data   = rf_data;
        hazard = 1'b0;
        src    = SRC_RF;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (tags[k].v && tags[k].wa == addr && addr != ZERO_ADDR) begin
                data   = stage_data[k*DATA_W +: DATA_W];
                hazard = en && !stage_dvalid[k];
                src    = src_of(k);
            end
        end
    end

endmodule

// File: rtl/fwd_bypass_net.sv
// Operand-forwarding network: in-flight destination tag pipeline plus
// one resolver per read channel. FWD_STATS_EN adds hit/stall counters.
module fwd_bypass_net
    import fwd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NREAD       = 2,
    parameter int DEPTH       = 3,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    adv,
    input  logic                    flush,
    input  logic                    issue_we,
    input  logic [AW-1:0]           issue_wa,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    input  logic [DEPTH-1:0]        stage_dvalid,
    input  logic [NREAD-1:0]        rd_en,
    input  logic [NREAD*AW-1:0]     rd_addr,
    input  logic [NREAD*DATA_W-1:0] rf_data,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_hazard,
    output logic [NREAD*2-1:0]      rd_src,
    output logic                    stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]             fwd_hits,
    output logic [31:0]             stall_cycles
`endif
);

    tag_t [DEPTH-1:0] tags;
    tag_t [DEPTH-1:0] held;
    tag_t             entry_in;

    // Flush squashes the youngest stages before any shift happens.
    always_comb begin
        held = tags;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush && k < FLUSH_DEPTH)
                held[k] = '0;
        end
        entry_in.v  = issue_we && issue_wa != ZERO_ADDR && !flush;
        entry_in.wa = issue_wa;
    end

    // Tag pipeline: shift on adv, otherwise hold (with flush applied).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags <= '0;
        end else if (adv) begin
            tags[0] <= entry_in;
            for (int k = 1; k < DEPTH; k++)
                tags[k] <= held[k-1];
        end else begin
            tags <= held;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_ch
        fwd_match #(
            .DATA_W(DATA_W),
            .DEPTH (DEPTH)
        ) u_match (
            .tags        (tags),
            .stage_data  (stage_data),
            .stage_dvalid(stage_dvalid),
            .en          (rd_en[i]),
            .addr        (rd_addr[i*AW +: AW]),
            .rf_data     (rf_data[i*DATA_W +: DATA_W]),
            .data        (rd_data[i*DATA_W +: DATA_W]),
            .hazard      (rd_hazard[i]),
            .src         (rd_src[i*2 +: 2])
        );
    end

    assign stall = |rd_hazard;

`ifdef FWD_STATS_EN
    logic hit;

    // A cycle counts as a hit if any live channel forwarded cleanly.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_en[i] && rd_src[i*2 +: 2] != SRC_RF && !rd_hazard[i])
                hit = 1'b1;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_hits     <= '0;
            stall_cycles <= '0;
        end else begin
            if (hit && fwd_hits != '1)
                fwd_hits <= fwd_hits + 32'd1;
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Directed testbench for fwd_bypass_net (default parameters).
// Stats checks compile in when FWD_STATS_EN is defined.
module tb_fwd_bypass_net;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int DP = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          adv;
    logic          flush;
    logic          issue_we;
    logic [5:0]    issue_wa;
    logic [DP*DW-1:0] stage_data;
    logic [DP-1:0] stage_dvalid;
    logic [NR-1:0] rd_en;
    logic [NR*6-1:0] rd_addr;
    logic [NR*DW-1:0] rf_data;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0] rd_hazard;
    logic [NR*2-1:0] rd_src;
    logic          stall;
`ifdef FWD_STATS_EN
    logic [31:0]   fwd_hits;
    logic [31:0]   stall_cycles;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    fwd_bypass_net #(
        .DATA_W(DW),
        .NREAD(NR),
        .DEPTH(DP),
        .FLUSH_DEPTH(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .adv         (adv),
        .flush       (flush),
        .issue_we    (issue_we),
        .issue_wa    (issue_wa),
        .stage_data  (stage_data),
        .stage_dvalid(stage_dvalid),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rf_data     (rf_data),
        .rd_data     (rd_data),
        .rd_hazard   (rd_hazard),
        .rd_src      (rd_src),
        .stall       (stall)
`ifdef FWD_STATS_EN
        ,
        .fwd_hits    (fwd_hits),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ch(input int i, input logic en, input logic [5:0] a,
                      input logic [31:0] rf);
        rd_en[i] = en;
        rd_addr[i*6 +: 6] = a;
        rf_data[i*DW +: DW] = rf;
    endtask

    task automatic sd(input int k, input logic [31:0] d);
        stage_data[k*DW +: DW] = d;
    endtask

    task automatic issue(input logic we, input logic [5:0] wa);
        issue_we = we;
        issue_wa = wa;
        adv = 1'b1;
        step();
        issue_we = 1'b0;
        adv = 1'b0;
    endtask

    function automatic logic [31:0] dat(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    function automatic logic [1:0] src(input int i);
        return rd_src[i*2 +: 2];
    endfunction

    initial begin
        reset = 1'b1;
        adv = 0; flush = 0; issue_we = 0; issue_wa = 0;
        stage_data = '0; stage_dvalid = '0;
        rd_en = '0; rd_addr = '0; rf_data = '0;
        step();
        step();
        reset = 1'b0;

        // reset state: everything from RF
        ch(0, 1, 6'd5, 32'h11);
        ch(1, 1, 6'd8, 32'h22);
        #1;
        chk("rst_data0", dat(0), 32'h11);
        chk("rst_src0", src(0), 2'b00);
        chk("rst_stall", stall, 1'b0);
        chk("rst_data1", dat(1), 32'h22);

        // forward from stage 0
        issue(1, 6'd5);
        sd(0, 32'hAA);
        stage_dvalid = 3'b111;
        #1;
        chk("s0_data", dat(0), 32'hAA);
        chk("s0_src", src(0), 2'b01);
        chk("s0_hz", rd_hazard[0], 1'b0);
        stage_dvalid = 3'b110;
        #1;
        chk("s0_hz_pend", rd_hazard[0], 1'b1);
        chk("s0_stall", stall, 1'b1);
        rd_en[0] = 1'b0;
        #1;
        chk("s0_en0_hz", rd_hazard[0], 1'b0);
        chk("s0_en0_data", dat(0), 32'hAA);
        rd_en[0] = 1'b1;
        stage_dvalid = 3'b111;

        // tag ages through stage 1, stage 2, then retires
        sd(1, 32'hBB);
        sd(2, 32'hCC);
        issue(0, 6'd0);
        chk("s1_data", dat(0), 32'hBB);
        chk("s1_src", src(0), 2'b10);
        issue(0, 6'd0);
        chk("s2_data", dat(0), 32'hCC);
        chk("s2_src", src(0), 2'b11);
        issue(0, 6'd0);
        chk("retired_data", dat(0), 32'h11);
        chk("retired_src", src(0), 2'b00);

        // youngest of two copies wins; pending young blocks old
        issue(1, 6'd8);
        issue(1, 6'd8);
        sd(0, 32'h2);
        sd(1, 32'h1);
        #1;
        chk("young_data", dat(1), 32'h2);
        chk("young_src", src(1), 2'b01);
        stage_dvalid = 3'b110;
        #1;
        chk("young_hz", rd_hazard[1], 1'b1);
        chk("young_stall", stall, 1'b1);
        stage_dvalid = 3'b111;

        // adv=0 holds: issued tag not captured
        issue_we = 1'b1; issue_wa = 6'd9;
        step();
        issue_we = 1'b0;
        ch(1, 1, 6'd9, 32'h99);
        #1;
        chk("hold_data", dat(1), 32'h99);
        ch(1, 1, 6'd8, 32'h22);
        #1;
        chk("hold_keep", src(1), 2'b01);

        // address 0 never forwarded
        issue(1, 6'd0);
        sd(0, 32'hFF);
        ch(0, 1, 6'd0, 32'h0);
        #1;
        chk("zero_data", dat(0), 32'h0);
        chk("zero_src", src(0), 2'b00);

        // HI forwarded, then squashed by flush+adv with issue
        issue(1, 6'd32);
        sd(0, 32'h5151);
        ch(0, 1, 6'd32, 32'h1234);
        #1;
        chk("hi_fwd", dat(0), 32'h5151);
        flush = 1'b1;
        issue(1, 6'd32);
        flush = 1'b0;
        stage_dvalid = 3'b000;
        #1;
        chk("flush_data", dat(0), 32'h1234);
        chk("flush_src", src(0), 2'b00);
        chk("flush_hz", rd_hazard[0], 1'b0);
        stage_dvalid = 3'b111;

        // LO, then flush without adv keeps older stages
        issue(1, 6'd7);
        issue(1, 6'd33);
        sd(1, 32'h7777);
        ch(0, 1, 6'd33, 32'h3333);
        ch(1, 1, 6'd7, 32'h4444);
        #1;
        chk("lo_src", src(0), 2'b01);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush0_lo", dat(0), 32'h3333);
        chk("flush0_old", dat(1), 32'h7777);
        chk("flush0_oldsrc", src(1), 2'b10);

        // async reset mid-cycle clears tags at once
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_data", dat(1), 32'h4444);
        chk("arst_src", src(1), 2'b00);
        step();
        reset = 1'b0;

`ifdef FWD_STATS_EN
        chk("st_hits0", fwd_hits, 32'd0);
        chk("st_stall0", stall_cycles, 32'd0);
        rd_en = 2'b00;
        issue(1, 6'd4);
        ch(0, 1, 6'd4, 32'h0);
        stage_dvalid = 3'b000;
        repeat (3) step();
        stage_dvalid = 3'b111;
        repeat (2) step();
        rd_en = 2'b00;
        #1;
        chk("st_stall", stall_cycles, 32'd3);
        chk("st_hits", fwd_hits, 32'd2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("st_rst_hits", fwd_hits, 32'd0);
        chk("st_rst_stall", stall_cycles, 32'd0);
        step();
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
